// File: rtl/sim_pkg.sv
// Shared types and constants for the fluid simulation frame scheduler.
package sim_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } sched_state_t;

  localparam int FIELD_DATAW_DEFAULT = 96;
  localparam int CURSOR_W            = 16;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: cleared on load, counts while enabled, flags expiry at TIMEOUT-1.
module stage_watchdog
  import sim_pkg::*;
#(
  parameter int  TIMEOUT = 4096,
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = en && (cnt_q == LIMIT);

endmodule

// File: rtl/sim_frame_scheduler.sv
// Frame controller: snapshots cursor/key per tick, sequences stages with start/done
// handshakes under a watchdog, and owns the field-memory write port (clear engine mux).
module sim_frame_scheduler
  import sim_pkg::*;
#(
  parameter int  FIELD_WIDTH  = 8,
  parameter int  FIELD_HEIGHT = 6,
  parameter int  FIELD_DATAW  = FIELD_DATAW_DEFAULT,
  parameter int  N_STAGES     = 3,
  parameter int  TIMEOUT      = 4096,
  localparam int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT,
  localparam int FIELD_ADDRW  = $clog2(FIELD_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   frame_tick,
  input  logic                   clear_req,
  input  logic [CURSOR_W-1:0]    cursor_x_in,
  input  logic [CURSOR_W-1:0]    cursor_y_in,
  input  logic                   key_in,
  output logic [CURSOR_W-1:0]    cursor_x,
  output logic [CURSOR_W-1:0]    cursor_y,
  output logic [CURSOR_W-1:0]    cursor_field_x_prev,
  output logic [CURSOR_W-1:0]    cursor_field_y_prev,
  output logic                   key_pressed,
  output logic [N_STAGES-1:0]    stage_start,
  input  logic [N_STAGES-1:0]    stage_done,
  input  logic [FIELD_DATAW-1:0] uf_field_data_in,
  input  logic [FIELD_ADDRW-1:0] uf_field_addr_write,
  input  logic                   uf_field_we,
  output logic [FIELD_DATAW-1:0] field_data_in,
  output logic [FIELD_ADDRW-1:0] field_addr_write,
  output logic                   field_we,
  output logic                   busy,
  output logic                   clearing,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [7:0]             overrun_cnt
);

  localparam int                     STG_W     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [STG_W-1:0]       LAST_STG  = STG_W'(N_STAGES - 1);
  localparam logic [FIELD_ADDRW-1:0] LAST_ADDR = FIELD_ADDRW'(FIELD_SIZE - 1);

  sched_state_t           state_q, state_d;
  logic [STG_W-1:0]       stg_q, stg_d;
  logic [FIELD_ADDRW-1:0] clr_addr_q, clr_addr_d;
  logic                   tick_pending, clear_pending;
  logic                   take_tick, start_clear, frame_end, wd_abort, wd_expire;
  logic                   tick_ok;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [N_STAGES-1:0] stage_onehot(input logic [STG_W-1:0] s);
    return N_STAGES'(1) << s;
  endfunction

  assign tick_ok = frame_tick && enable;

  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == S_START),
    .en     (state_q == S_WAIT),
    .expire (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    stg_d       = stg_q;
    clr_addr_d  = clr_addr_q;
    take_tick   = 1'b0;
    start_clear = 1'b0;
    frame_end   = 1'b0;
    wd_abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_pending) begin
          state_d     = S_CLEAR;
          clr_addr_d  = '0;
          start_clear = 1'b1;
        end else if (tick_pending) begin
          state_d   = S_START;
          stg_d     = '0;
          take_tick = 1'b1;
        end
      end
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) state_d = S_IDLE;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // A done from the active stage wins over a watchdog expiry in the same cycle.
        if (stage_done[stg_q]) begin
          if (stg_q < LAST_STG) begin
            stg_d   = stg_q + 1'b1;
            state_d = S_START;
          end else begin
            frame_end = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (wd_expire) begin
          wd_abort  = 1'b1;
          frame_end = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      stg_q      <= '0;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      stg_q      <= stg_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Request queues; the clear flag drops on entry so a request mid-clear reruns it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_pending  <= 1'b0;
      clear_pending <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      if (take_tick)    tick_pending <= 1'b0;
      else if (tick_ok) tick_pending <= 1'b1;
      if (tick_ok && tick_pending) overrun_cnt <= sat_inc8(overrun_cnt);
      if (clear_req)        clear_pending <= 1'b1;
      else if (start_clear) clear_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cursor_x            <= '0;
      cursor_y            <= '0;
      cursor_field_x_prev <= '0;
      cursor_field_y_prev <= '0;
      key_pressed         <= 1'b0;
    end else if (take_tick) begin
      cursor_field_x_prev <= cursor_x;
      cursor_field_y_prev <= cursor_y;
      cursor_x            <= cursor_x_in;
      cursor_y            <= cursor_y_in;
      key_pressed         <= key_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_start <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      stage_start <= (state_d == S_START) ? stage_onehot(stg_d) : '0;
      frame_done  <= frame_end;
      frame_err   <= frame_err | wd_abort;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign clearing = (state_q == S_CLEAR);

  always_comb begin
    field_we         = 1'b0;
    field_data_in    = '0;
    field_addr_write = '0;
    if (state_q == S_CLEAR) begin
      field_we         = 1'b1;
      field_addr_write = clr_addr_q;
    end else if ((state_q == S_WAIT) && (stg_q == '0)) begin
      field_we         = uf_field_we;
      field_data_in    = uf_field_data_in;
      field_addr_write = uf_field_addr_write;
    end
  end

endmodule

// File: tb/tb_sim_frame_scheduler.sv
// Bench for sim_frame_scheduler: behavioural model checked every cycle, plus directed scenarios.
module tb_sim_frame_scheduler;

  localparam int FS  = 48;
  localparam int AW  = 6;
  localparam int DW  = 96;
  localparam int NS  = 3;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          frame_tick = 1'b0;
  logic          clear_req = 1'b0;
  logic [15:0]   cursor_x_in = '0, cursor_y_in = '0;
  logic          key_in = 1'b0;
  logic [15:0]   cursor_x, cursor_y, cursor_field_x_prev, cursor_field_y_prev;
  logic          key_pressed;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done = '0;
  logic [DW-1:0] uf_field_data_in = '0;
  logic [AW-1:0] uf_field_addr_write = '0;
  logic          uf_field_we = 1'b0;
  logic [DW-1:0] field_data_in;
  logic [AW-1:0] field_addr_write;
  logic          field_we, busy, clearing, frame_done, frame_err;
  logic [7:0]    overrun_cnt;

  sim_frame_scheduler #(
    .FIELD_WIDTH(8), .FIELD_HEIGHT(6), .FIELD_DATAW(DW), .N_STAGES(NS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick), .clear_req(clear_req),
    .cursor_x_in(cursor_x_in), .cursor_y_in(cursor_y_in), .key_in(key_in),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .cursor_field_x_prev(cursor_field_x_prev), .cursor_field_y_prev(cursor_field_y_prev),
    .key_pressed(key_pressed), .stage_start(stage_start), .stage_done(stage_done),
    .uf_field_data_in(uf_field_data_in), .uf_field_addr_write(uf_field_addr_write),
    .uf_field_we(uf_field_we), .field_data_in(field_data_in),
    .field_addr_write(field_addr_write), .field_we(field_we), .busy(busy),
    .clearing(clearing), .frame_done(frame_done), .frame_err(frame_err),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stage responders: answer done 5 cycles after seeing their start, if enabled.
  logic [NS-1:0] resp_en = '1;
  int resp_cnt [NS];
  always @(posedge clk) begin
    #1;
    stage_done = '0;
    for (int s = 0; s < NS; s++) begin
      if (!reset) resp_cnt[s] = 0;
      else if (resp_cnt[s] > 0) begin
        resp_cnt[s] = resp_cnt[s] - 1;
        if (resp_cnt[s] == 0) stage_done[s] = 1'b1;
      end
      if (reset && stage_start[s] && resp_en[s]) resp_cnt[s] = 5;
    end
  end

  // update_field write traffic that changes every cycle.
  always @(posedge clk) begin
    #1;
    uf_field_we         = cyc[0];
    uf_field_addr_write = AW'(cyc % FS);
    uf_field_data_in    = {32'(cyc), ~32'(cyc), 32'hA5A5_0000 + 32'(cyc)};
  end

  // Behavioural model: a frame is an idle gap, an optional clear sweep, then a start/wait run per stage.
  int          m_clr_left, m_stage, m_waited, m_ovr;
  bit          m_start, m_tick_q, m_clear_q, m_fd, m_err, m_key;
  logic [15:0] m_cx, m_cy, m_px, m_py;
  bit          m_idle, m_take, m_sclr, m_tk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_clr_left = 0; m_stage = -1; m_waited = 0; m_ovr = 0;
      m_start = 0; m_tick_q = 0; m_clear_q = 0; m_fd = 0; m_err = 0; m_key = 0;
      m_cx = 0; m_cy = 0; m_px = 0; m_py = 0;
    end else begin
      m_idle = (m_clr_left == 0) && (m_stage < 0);
      m_take = 0; m_sclr = 0; m_fd = 0;
      m_tk   = frame_tick && enable;
      if (m_idle) begin
        if (m_clear_q) begin
          m_clr_left = FS; m_sclr = 1;
        end else if (m_tick_q) begin
          m_take = 1; m_stage = 0; m_start = 1;
          m_px = m_cx; m_py = m_cy; m_cx = cursor_x_in; m_cy = cursor_y_in; m_key = key_in;
        end
      end else if (m_clr_left > 0) begin
        m_clr_left--;
      end else if (m_start) begin
        m_start = 0; m_waited = 1;
      end else if (stage_done[m_stage]) begin
        if (m_stage < NS - 1) begin m_stage++; m_start = 1; end
        else begin m_stage = -1; m_fd = 1; end
      end else if (m_waited == TMO) begin
        m_stage = -1; m_fd = 1; m_err = 1;
      end else begin
        m_waited++;
      end
      if (m_tk && m_tick_q && m_ovr < 255) m_ovr++;
      m_tick_q  = m_take ? 1'b0 : (m_tick_q | m_tk);
      m_clear_q = clear_req ? 1'b1 : (m_sclr ? 1'b0 : m_clear_q);
    end
  end

  bit            run_cmp = 0;
  logic [NS-1:0] e_start;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  always @(negedge clk) begin
    if (run_cmp) begin
      e_start = m_start ? NS'(1 << m_stage) : '0;
      e_we = 0; e_addr = '0; e_data = '0;
      if (m_clr_left > 0) begin
        e_we = 1; e_addr = AW'(FS - m_clr_left);
      end else if (m_stage == 0 && !m_start) begin
        e_we = uf_field_we; e_addr = uf_field_addr_write; e_data = uf_field_data_in;
      end
      chk("cmp_stage_start", 128'(stage_start), 128'(e_start));
      chk("cmp_busy", 128'(busy), 128'(!((m_clr_left == 0) && (m_stage < 0))));
      chk("cmp_clearing", 128'(clearing), 128'(m_clr_left > 0));
      chk("cmp_field_we", 128'(field_we), 128'(e_we));
      chk("cmp_field_addr", 128'(field_addr_write), 128'(e_addr));
      chk("cmp_field_data", 128'(field_data_in), 128'(e_data));
      chk("cmp_frame_done", 128'(frame_done), 128'(m_fd));
      chk("cmp_frame_err", 128'(frame_err), 128'(m_err));
      chk("cmp_overrun", 128'(overrun_cnt), 128'(m_ovr));
      chk("cmp_cursor", 128'({cursor_x, cursor_y, key_pressed}), 128'({m_cx, m_cy, m_key}));
      chk("cmp_cursor_prev", 128'({cursor_field_x_prev, cursor_field_y_prev}), 128'({m_px, m_py}));
    end
  end

  // Event logs for the directed scenarios.
  int st_log[$];
  int st_cyc[$];
  int fd_cnt = 0, fd_cyc = 0, clr_writes = 0, clr_bad = 0;

  always @(negedge clk) begin
    for (int s = 0; s < NS; s++)
      if (stage_start[s]) begin st_log.push_back(s); st_cyc.push_back(cyc); end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (clearing) begin
      if (field_we !== 1'b1 || field_data_in !== '0 || field_addr_write !== AW'(clr_writes)) clr_bad++;
      clr_writes++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    st_log.delete(); st_cyc.delete();
    fd_cnt = 0; clr_writes = 0; clr_bad = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    clear_logs();
    reset = 1'b1;
    step(1);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  int t0;

  initial begin
    #1 reset = 1'b0;
    run_cmp = 1;
    step(3);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_stage_start", 128'(stage_start), 128'(0));
    chk("rst_overrun", 128'(overrun_cnt), 128'(0));
    chk("rst_field_we", 128'(field_we), 128'(0));
    chk("rst_frame_err", 128'(frame_err), 128'(0));
    reset = 1'b1;
    step(2);

    // Normal frame with cursor (100,100), key down; latency and handoff spacing.
    enable = 1; resp_en = '1; cursor_x_in = 100; cursor_y_in = 100; key_in = 1;
    clear_logs();
    t0 = cyc;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", 128'(stage_start), 128'(0));
    @(negedge clk);
    chk("lat_cycle2", 128'(stage_start), 128'(3'b001));
    step(40);
    chk("nf_start_count", 128'(st_log.size()), 128'(3));
    chk("nf_order", 128'({st_log[0][1:0], st_log[1][1:0], st_log[2][1:0]}), 128'(6'b00_01_10));
    chk("nf_tick_to_start0", 128'(st_cyc[0] - t0), 128'(2));
    chk("nf_handoff01", 128'(st_cyc[1] - st_cyc[0]), 128'(6));
    chk("nf_handoff12", 128'(st_cyc[2] - st_cyc[1]), 128'(6));
    chk("nf_done_lat", 128'(fd_cyc - st_cyc[2]), 128'(6));
    chk("nf_done_count", 128'(fd_cnt), 128'(1));
    chk("nf_frame_err", 128'(frame_err), 128'(0));

    // Second frame at (120,90); enable drops mid-frame and live inputs change after snapshot.
    clear_logs();
    cursor_x_in = 120; cursor_y_in = 90; key_in = 0;
    pulse_tick();
    step(1);
    enable = 0; cursor_x_in = 7; cursor_y_in = 7; key_in = 1;
    step(2);
    chk("snap_x", 128'(cursor_x), 128'(120));
    chk("snap_y", 128'(cursor_y), 128'(90));
    chk("snap_prev_x", 128'(cursor_field_x_prev), 128'(100));
    chk("snap_prev_y", 128'(cursor_field_y_prev), 128'(100));
    chk("snap_key", 128'(key_pressed), 128'(0));
    step(40);
    chk("en_low_frame_completes", 128'(fd_cnt), 128'(1));
    enable = 1;

    // Clear and tick in the same cycle: 48 zero writes, then stage 0 starts.
    clear_logs();
    t0 = cyc;
    clear_req = 1; frame_tick = 1;
    step(1);
    clear_req = 0; frame_tick = 0;
    step(90);
    chk("clr_writes", 128'(clr_writes), 128'(FS));
    chk("clr_bad", 128'(clr_bad), 128'(0));
    chk("clr_to_start0", 128'(st_cyc[0] - t0), 128'(51));
    chk("clr_frame_done", 128'(fd_cnt), 128'(1));

    // Overrun: three ticks during one frame, one extra frame follows.
    do_reset();
    pulse_tick();
    step(2); pulse_tick();
    step(1); pulse_tick();
    step(1); pulse_tick();
    step(80);
    chk("ovr_count", 128'(overrun_cnt), 128'(2));
    chk("ovr_frames", 128'(fd_cnt), 128'(2));
    chk("ovr_starts", 128'(st_log.size()), 128'(6));
    chk("ovr_idle", 128'(busy), 128'(0));

    // Disabled ticks are ignored; continuous ticking saturates the overrun counter.
    do_reset();
    enable = 0;
    for (int i = 0; i < 4; i++) begin pulse_tick(); step(1); end
    chk("dis_overrun", 128'(overrun_cnt), 128'(0));
    chk("dis_no_start", 128'(st_log.size()), 128'(0));
    enable = 1;
    frame_tick = 1;
    step(300);
    frame_tick = 0;
    chk("sat_overrun", 128'(overrun_cnt), 128'(255));

    // Timeout: stage 1 never answers.
    do_reset();
    resp_en = 3'b101;
    pulse_tick();
    step(150);
    chk("to_frame_err", 128'(frame_err), 128'(1));
    chk("to_frame_done", 128'(fd_cnt), 128'(1));
    chk("to_starts", 128'(st_log.size()), 128'(2));
    chk("to_abort_lat", 128'(fd_cyc - st_cyc[1]), 128'(TMO + 1));

    // Mid-frame reset during stage 1 wait.
    clear_logs();
    pulse_tick();
    step(14);
    chk("mr_busy_before", 128'(busy), 128'(1));
    reset = 1'b0;
    #1;
    chk("mr_busy", 128'(busy), 128'(0));
    chk("mr_outputs", 128'({stage_start, frame_err, frame_done, clearing, field_we, key_pressed}), 128'(0));
    chk("mr_cursor", 128'({cursor_x, cursor_y, cursor_field_x_prev, cursor_field_y_prev, overrun_cnt}), 128'(0));
    clear_logs();
    step(1);
    pulse_tick();
    step(4);
    chk("mr_no_start_in_reset", 128'(st_log.size()), 128'(0));
    reset = 1'b1;
    resp_en = '1;
    step(1);
    pulse_tick();
    step(40);
    chk("mr_restart_stage0", 128'(st_log[0]), 128'(0));
    chk("mr_restart_frames", 128'(fd_cnt), 128'(1));

    run_cmp = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
